// File: rtl/memory_access_stage_pkg.sv
// Shared widths and types for the memory access stage.
// Holds the memory-op decode used by the stage datapath.
package definitions;

    localparam int DATA_WIDTH     = 8;
    localparam int REG_ADDR_WIDTH = 3;
    localparam int COUNT_WIDTH    = 16;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_LOAD,
        OP_STORE,
        OP_ILLEGAL
    } mem_op_e;

    typedef enum logic {
        BUF_EMPTY,
        BUF_FULL
    } buf_state_e;

    function automatic mem_op_e decode_op(
        input logic is_load,
        input logic is_store
    );
        mem_op_e op;
        unique case ({is_load, is_store})
            2'b10:   op = OP_LOAD;
            2'b01:   op = OP_STORE;
            2'b11:   op = OP_ILLEGAL;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/memory_access_stage_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Ports: _CLK, _RESET, _inc (count enable), count (current value, sticks at all-ones).
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             _CLK,
    input  logic             _RESET,
    input  logic             _inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (_RESET) begin
            count_d = '0;
        end else if (_inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge _CLK) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/memory_access_stage.sv
// Memory access stage: drives data memory for an accepted op and buffers the
// result for writeback. Ports: execute-side valid/ready op inputs, data memory
// strobes/address/data, one-entry writeback output, load/store counters, illegalOp.
module memory_access_stage #(
    parameter int DATA_WIDTH     = definitions::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = definitions::REG_ADDR_WIDTH,
    parameter int COUNT_WIDTH    = definitions::COUNT_WIDTH
) (
    input  logic                      _CLK,
    input  logic                      _RESET,
    input  logic                      _inValid,
    output logic                      inReady,
    input  logic                      _isLoad,
    input  logic                      _isStore,
    input  logic [DATA_WIDTH-1:0]     _address,
    input  logic [DATA_WIDTH-1:0]     _storeValue,
    input  logic [DATA_WIDTH-1:0]     _aluResult,
    input  logic [REG_ADDR_WIDTH-1:0] _destReg,
    output logic                      memRead,
    output logic                      memWrite,
    output logic [DATA_WIDTH-1:0]     memAddress,
    output logic [DATA_WIDTH-1:0]     memValueIn,
    input  logic [DATA_WIDTH-1:0]     _memValueOut,
    output logic                      outValid,
    input  logic                      _outReady,
    output logic [DATA_WIDTH-1:0]     outValue,
    output logic [REG_ADDR_WIDTH-1:0] outDestReg,
    output logic                      outWriteEnable,
    output logic [COUNT_WIDTH-1:0]    loadCount,
    output logic [COUNT_WIDTH-1:0]    storeCount,
    output logic                      illegalOp
);

    import definitions::*;

    buf_state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0]     value_q, value_d;
    logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
    logic                      we_q, we_d;
    logic                      illegal_q, illegal_d;

    mem_op_e op;
    logic    in_ready;
    logic    accept;

    always_comb begin
        op       = decode_op(_isLoad, _isStore);
        in_ready = !_RESET && ((state_q == BUF_EMPTY) || _outReady);
        accept   = _inValid && in_ready;
    end

    // Buffer state register and payload
    always_ff @(posedge _CLK) begin
        state_q   <= state_d;
        value_q   <= value_d;
        dest_q    <= dest_d;
        we_q      <= we_d;
        illegal_q <= illegal_d;
    end

    // Next-state and payload
    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        dest_d    = dest_q;
        we_d      = we_q;
        illegal_d = illegal_q;

        unique case (state_q)
            BUF_EMPTY: if (accept) state_d = BUF_FULL;
            BUF_FULL: begin
                if (accept)         state_d = BUF_FULL;
                else if (_outReady) state_d = BUF_EMPTY;
            end
            default: state_d = BUF_EMPTY;
        endcase

        if (accept) begin
            dest_d = _destReg;
            unique case (op)
                OP_LOAD: begin
                    value_d = _memValueOut;
                    we_d    = 1'b1;
                end
                OP_STORE: begin
                    value_d = _storeValue;
                    we_d    = 1'b0;
                end
                OP_ILLEGAL: begin
                    value_d   = '0;
                    we_d      = 1'b0;
                    illegal_d = 1'b1;
                end
                default: begin
                    value_d = _aluResult;
                    we_d    = 1'b1;
                end
            endcase
        end

        if (_RESET) begin
            state_d   = BUF_EMPTY;
            value_d   = '0;
            dest_d    = '0;
            we_d      = 1'b0;
            illegal_d = 1'b0;
        end
    end

    // Outputs; accept already excludes reset, so strobes are low in reset
    always_comb begin
        inReady        = in_ready;
        memRead        = accept && (op == OP_LOAD);
        memWrite       = accept && (op == OP_STORE);
        memAddress     = _address;
        memValueIn     = _storeValue;
        outValid       = (state_q == BUF_FULL);
        outValue       = value_q;
        outDestReg     = dest_q;
        outWriteEnable = we_q;
        illegalOp      = illegal_q;
    end

    saturating_counter #(.WIDTH(COUNT_WIDTH)) u_load_cnt (
        ._CLK   (_CLK),
        ._RESET (_RESET),
        ._inc   (accept && (op == OP_LOAD)),
        .count  (loadCount)
    );

    saturating_counter #(.WIDTH(COUNT_WIDTH)) u_store_cnt (
        ._CLK   (_CLK),
        ._RESET (_RESET),
        ._inc   (accept && (op == OP_STORE)),
        .count  (storeCount)
    );

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage with a behavioural memory model.
// Driver predicts handshake and pushes expected entries; monitor pops and checks.
module tb_memory_access_stage;

    localparam int DW = 8;
    localparam int RW = 3;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          is_load;
    logic          is_store;
    logic [DW-1:0] address;
    logic [DW-1:0] store_value;
    logic [DW-1:0] alu_result;
    logic [RW-1:0] dest_reg;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_address;
    logic [DW-1:0] mem_value_in;
    logic [DW-1:0] mem_value_out;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_value;
    logic [RW-1:0] out_dest;
    logic          out_we;
    logic [CW-1:0] load_count;
    logic [CW-1:0] store_count;
    logic          illegal_op;

    memory_access_stage #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (RW),
        .COUNT_WIDTH    (CW)
    ) dut (
        ._CLK           (clk),
        ._RESET         (rst),
        ._inValid       (in_valid),
        .inReady        (in_ready),
        ._isLoad        (is_load),
        ._isStore       (is_store),
        ._address       (address),
        ._storeValue    (store_value),
        ._aluResult     (alu_result),
        ._destReg       (dest_reg),
        .memRead        (mem_read),
        .memWrite       (mem_write),
        .memAddress     (mem_address),
        .memValueIn     (mem_value_in),
        ._memValueOut   (mem_value_out),
        .outValid       (out_valid),
        ._outReady      (out_ready),
        .outValue       (out_value),
        .outDestReg     (out_dest),
        .outWriteEnable (out_we),
        .loadCount      (load_count),
        .storeCount     (store_count),
        .illegalOp      (illegal_op)
    );

    always #5 clk = ~clk;

    // Environment data memory: commits on the edge, reads combinationally
    logic [DW-1:0] env_mem [256];
    always @(posedge clk) begin
        if (mem_write) env_mem[mem_address] <= mem_value_in;
    end
    assign mem_value_out = env_mem[mem_address];

    typedef struct {
        logic [DW-1:0] value;
        logic [RW-1:0] dest;
        logic          we;
    } entry_t;

    entry_t exp_q[$];

    int total = 0;
    int bad = 0;
    bit started = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [256];
    bit m_full = 0;
    int m_loads = 0;
    int m_stores = 0;
    bit m_illegal = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (started) begin
            if (!out_valid) begin
                chk("out_empty_queue", exp_q.size(), 0);
            end else if (exp_q.size() == 0) begin
                chk("out_unexpected_valid", 1, 0);
            end else begin
                chk("outValue", out_value, exp_q[0].value);
                chk("outDestReg", out_dest, exp_q[0].dest);
                chk("outWriteEnable", out_we, exp_q[0].we);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(
        input logic          r,
        input logic          v,
        input logic          ld,
        input logic          st,
        input logic [DW-1:0] a,
        input logic [DW-1:0] sv,
        input logic [DW-1:0] alu,
        input logic [RW-1:0] d,
        input logic          ordy
    );
        bit exp_ready;
        bit acc;
        entry_t e;
        @(posedge clk);
        #1;
        started = 1;
        rst = r; in_valid = v; is_load = ld; is_store = st;
        address = a; store_value = sv; alu_result = alu;
        dest_reg = d; out_ready = ordy;
        @(negedge clk);
        #2;
        exp_ready = !r && (!m_full || ordy);
        acc = v && exp_ready;
        chk("inReady", in_ready, exp_ready);
        chk("memRead", mem_read, acc && ld && !st);
        chk("memWrite", mem_write, acc && st && !ld);
        chk("memAddress", mem_address, a);
        chk("memValueIn", mem_value_in, sv);
        chk("loadCount", load_count, m_loads);
        chk("storeCount", store_count, m_stores);
        chk("illegalOp", illegal_op, m_illegal);
        if (r) begin
            m_full = 0;
            m_loads = 0;
            m_stores = 0;
            m_illegal = 0;
            exp_q.delete();
        end else begin
            if (acc) begin
                e.dest = d;
                if (ld && st) begin
                    e.value = '0; e.we = 0; m_illegal = 1;
                end else if (ld) begin
                    e.value = ref_mem[a]; e.we = 1;
                    if (m_loads < CMAX) m_loads++;
                end else if (st) begin
                    e.value = sv; e.we = 0;
                    ref_mem[a] = sv;
                    if (m_stores < CMAX) m_stores++;
                end else begin
                    e.value = alu; e.we = 1;
                end
                exp_q.push_back(e);
                m_full = 1;
            end else if (ordy) begin
                m_full = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        rst = 1; in_valid = 1; is_load = 0; is_store = 1;
        address = 8'h44; store_value = 8'h99; alu_result = 0;
        dest_reg = 0; out_ready = 1;

        // Reset with a store presented
        step(1, 1, 0, 1, 8'h44, 8'h99, 0, 0, 1);
        step(1, 1, 0, 1, 8'h44, 8'h99, 0, 0, 1);
        chk("reset_outValue", out_value, 0);
        chk("reset_outDestReg", out_dest, 0);
        chk("reset_outWe", out_we, 0);
        chk("reset_no_write", env_mem[8'h44], ref_mem[8'h44]);

        // Store then load to the same address
        step(0, 1, 0, 1, 8'h10, 8'hA5, 0, 1, 1);
        step(0, 1, 1, 0, 8'h10, 0, 0, 3, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Backpressure with a load waiting
        step(0, 1, 0, 0, 0, 0, 8'h3C, 5, 1);
        step(0, 1, 1, 0, 8'h10, 0, 0, 2, 0);
        step(0, 1, 1, 0, 8'h10, 0, 0, 2, 0);
        step(0, 1, 1, 0, 8'h10, 0, 0, 2, 0);
        step(0, 1, 1, 0, 8'h10, 0, 0, 2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Back-to-back throughput
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0, 8'(i), 3'(i), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Illegal op, then normal traffic keeps the flag set
        step(0, 1, 1, 1, 8'h20, 8'h77, 0, 6, 1);
        step(0, 1, 0, 0, 0, 0, 8'h11, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Load counter saturation
        for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 8'(i * 13), 0, 0, 4, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("load_saturated", load_count, CMAX);

        // Reset with a pending entry and a store
        step(0, 1, 0, 0, 0, 0, 8'h5A, 2, 0);
        step(1, 1, 0, 1, 8'h30, 8'hEE, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("reset_store_dropped", env_mem[8'h30], ref_mem[8'h30]);

        // Random traffic; small address set for read-after-write hits
        for (int i = 0; i < 600; i++) begin
            logic ld, st;
            ld = ($urandom_range(0, 9) < 4);
            st = ($urandom_range(0, 9) < 4);
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0), ld, st,
                 8'($urandom_range(0, 7) * 37), 8'($urandom),
                 8'($urandom), 3'($urandom),
                 ($urandom_range(0, 9) < 7));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 256; i++) chk("mem_final", env_mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
